// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multicycle controller and the
// instruction/data memory ports.
interface multicycle_ctrl_if;
   logic imem_req;
   logic imem_ack;
   logic dmem_req;
   logic dmem_we;
   logic dmem_ack;

   modport master (
      output imem_req,
      output dmem_req,
      output dmem_we,
      input  imem_ack,
      input  dmem_ack
   );

   modport slave (
      input  imem_req,
      input  dmem_req,
      input  dmem_we,
      output imem_ack,
      output dmem_ack
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Shared encodings for the multicycle controller and its datapath.
package params_pkg;
   typedef enum logic [6:0] {
      LOAD   = 7'b0000011,
      STORE  = 7'b0100011,
      ARITH  = 7'b0110011,
      BRANCH = 7'b1100011
   } opcode_t;

   typedef enum logic [2:0] {
      AND = 3'b000,
      OR  = 3'b001,
      ADD = 3'b010,
      SUB = 3'b110
   } alu_ctrl_t;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd7
   } state_t;
endpackage

// Multicycle instruction controller: sequences fetch, decode, execute,
// memory access and writeback, drives the datapath strobes, counts retired
// instructions and parks in TRAP on an illegal instruction until reset.
module multicycle_ctrl
   import params_pkg::*;
#(
   parameter int INSTRET_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [6:0]               opcode,
   input  logic [2:0]               funct3,
   input  logic                     funct7_b5,
   input  logic                     alu_zero,
   multicycle_ctrl_if.master        mem,
   output logic                     ir_write,
   output logic                     pc_write,
   output logic                     pc_src,
   output logic                     reg_write,
   output logic                     mem_to_reg,
   output logic                     alu_src,
   output logic [2:0]               alu_ctrl,
   output logic                     trap,
   output logic [INSTRET_WIDTH-1:0] instret,
   output logic [2:0]               state
);

   state_t                   state_q, state_d;
   logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
   alu_ctrl_t                alu_hold_q, alu_hold_d;
   logic                     is_load_q, is_load_d;

   alu_ctrl_t exec_alu;
   logic      exec_legal;

   logic      imem_req_c, dmem_req_c, dmem_we_c;
   logic      ir_write_c, pc_write_c, pc_src_c;
   logic      reg_write_c, mem_to_reg_c, alu_src_c, trap_c;
   alu_ctrl_t alu_ctrl_c;

   // Decode the ALU operation for the current instruction and flag funct3 values we cannot execute.
   always_comb begin
      exec_alu   = ADD;
      exec_legal = 1'b0;
      case (opcode)
         LOAD, STORE: begin
            exec_alu   = ADD;
            exec_legal = 1'b1;
         end
         BRANCH: begin
            exec_alu   = SUB;
            exec_legal = 1'b1;
         end
         ARITH: begin
            case (funct3)
               3'b000: begin
                  exec_alu   = funct7_b5 ? SUB : ADD;
                  exec_legal = 1'b1;
               end
               3'b111: begin
                  exec_alu   = AND;
                  exec_legal = 1'b1;
               end
               3'b110: begin
                  exec_alu   = OR;
                  exec_legal = 1'b1;
               end
               default: begin
                  exec_alu   = ADD;
                  exec_legal = 1'b0;
               end
            endcase
         end
         default: begin
            exec_alu   = ADD;
            exec_legal = 1'b0;
         end
      endcase
   end

   // Next-state, retire counting and per-state strobes; reset forces every strobe low immediately.
   always_comb begin
      state_d      = state_q;
      instret_d    = instret_q;
      alu_hold_d   = alu_hold_q;
      is_load_d    = is_load_q;
      imem_req_c   = 1'b0;
      dmem_req_c   = 1'b0;
      dmem_we_c    = 1'b0;
      ir_write_c   = 1'b0;
      pc_write_c   = 1'b0;
      pc_src_c     = 1'b0;
      reg_write_c  = 1'b0;
      mem_to_reg_c = 1'b0;
      alu_src_c    = 1'b0;
      trap_c       = 1'b0;
      alu_ctrl_c   = ADD;

      case (state_q)
         FETCH: begin
            imem_req_c = 1'b1;
            if (mem.imem_ack) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               state_d    = DECODE;
            end
         end
         DECODE: begin
            if ((opcode == LOAD) || (opcode == STORE) ||
                (opcode == ARITH) || (opcode == BRANCH)) begin
               state_d = EXEC;
            end else begin
               state_d = TRAP;
            end
         end
         EXEC: begin
            alu_ctrl_c = exec_alu;
            alu_hold_d = exec_alu;
            if (!exec_legal) begin
               state_d = TRAP;
            end else begin
               case (opcode)
                  LOAD, STORE: begin
                     alu_src_c = 1'b1;
                     is_load_d = (opcode == LOAD);
                     state_d   = MEM;
                  end
                  BRANCH: begin
                     state_d   = FETCH;
                     instret_d = instret_q + INSTRET_WIDTH'(1);
                     if (alu_zero) begin
                        pc_write_c = 1'b1;
                        pc_src_c   = 1'b1;
                     end
                  end
                  default: begin
                     // Only ARITH reaches here: the legality decode rejects everything else.
                     is_load_d = 1'b0;
                     state_d   = WB;
                  end
               endcase
            end
         end
         MEM: begin
            dmem_req_c = 1'b1;
            dmem_we_c  = !is_load_q;
            alu_ctrl_c = alu_hold_q;
            if (mem.dmem_ack) begin
               if (is_load_q) begin
                  state_d = WB;
               end else begin
                  state_d   = FETCH;
                  instret_d = instret_q + INSTRET_WIDTH'(1);
               end
            end
         end
         WB: begin
            reg_write_c  = 1'b1;
            mem_to_reg_c = is_load_q;
            alu_ctrl_c   = alu_hold_q;
            state_d      = FETCH;
            instret_d    = instret_q + INSTRET_WIDTH'(1);
         end
         TRAP: begin
            trap_c = 1'b1;
         end
         default: begin
            state_d = FETCH;
         end
      endcase

      if (!rst_n) begin
         imem_req_c   = 1'b0;
         dmem_req_c   = 1'b0;
         dmem_we_c    = 1'b0;
         ir_write_c   = 1'b0;
         pc_write_c   = 1'b0;
         pc_src_c     = 1'b0;
         reg_write_c  = 1'b0;
         mem_to_reg_c = 1'b0;
         alu_src_c    = 1'b0;
         trap_c       = 1'b0;
         alu_ctrl_c   = ADD;
      end
   end

   // State, retire counter and the per-instruction context held from EXEC through WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         instret_q  <= '0;
         alu_hold_q <= ADD;
         is_load_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         instret_q  <= instret_d;
         alu_hold_q <= alu_hold_d;
         is_load_q  <= is_load_d;
      end
   end

   assign mem.imem_req = imem_req_c;
   assign mem.dmem_req = dmem_req_c;
   assign mem.dmem_we  = dmem_we_c;
   assign ir_write     = ir_write_c;
   assign pc_write     = pc_write_c;
   assign pc_src       = pc_src_c;
   assign reg_write    = reg_write_c;
   assign mem_to_reg   = mem_to_reg_c;
   assign alu_src      = alu_src_c;
   assign alu_ctrl     = alu_ctrl_c;
   assign trap         = trap_c;
   assign instret      = instret_q;
   assign state        = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a 32-bit-counter instance and a 4-bit-counter
// instance share all stimulus; per-cycle expectations are queued as they are
// driven and compared once the outputs have settled.
module tb_multicycle_ctrl;
   import params_pkg::*;

   localparam logic [9:0] IREQ = 10'h200;
   localparam logic [9:0] DREQ = 10'h100;
   localparam logic [9:0] DWE  = 10'h080;
   localparam logic [9:0] IRW  = 10'h040;
   localparam logic [9:0] PCW  = 10'h020;
   localparam logic [9:0] PCS  = 10'h010;
   localparam logic [9:0] RW   = 10'h008;
   localparam logic [9:0] M2R  = 10'h004;
   localparam logic [9:0] ASRC = 10'h002;
   localparam logic [9:0] TRP  = 10'h001;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       z;
      logic       iack;
      logic       dack;
      logic [2:0] st;
      logic [9:0] outs;
      logic [2:0] alu;
      int         ret;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic       funct7_b5 = 1'b0;
   logic       alu_zero = 1'b0;

   int checks = 0;
   int failures = 0;
   int row_no = 0;
   vec_t sb[$];
   vec_t tbl[$];
   vec_t cur;

   multicycle_ctrl_if bus32 ();
   multicycle_ctrl_if bus4 ();

   logic        ir_write_a, pc_write_a, pc_src_a, reg_write_a, mem_to_reg_a, alu_src_a, trap_a;
   logic [2:0]  alu_ctrl_a, state_a;
   logic [31:0] instret_a;
   logic        ir_write_b, pc_write_b, pc_src_b, reg_write_b, mem_to_reg_b, alu_src_b, trap_b;
   logic [2:0]  alu_ctrl_b, state_b;
   logic [3:0]  instret_b;
   logic [9:0]  outs_a;

   assign outs_a = {bus32.imem_req, bus32.dmem_req, bus32.dmem_we, ir_write_a, pc_write_a,
                    pc_src_a, reg_write_a, mem_to_reg_a, alu_src_a, trap_a};

   multicycle_ctrl #(.INSTRET_WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
      .alu_zero(alu_zero), .mem(bus32.master), .ir_write(ir_write_a), .pc_write(pc_write_a),
      .pc_src(pc_src_a), .reg_write(reg_write_a), .mem_to_reg(mem_to_reg_a), .alu_src(alu_src_a),
      .alu_ctrl(alu_ctrl_a), .trap(trap_a), .instret(instret_a), .state(state_a)
   );

   multicycle_ctrl #(.INSTRET_WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
      .alu_zero(alu_zero), .mem(bus4.master), .ir_write(ir_write_b), .pc_write(pc_write_b),
      .pc_src(pc_src_b), .reg_write(reg_write_b), .mem_to_reg(mem_to_reg_b), .alu_src(alu_src_b),
      .alu_ctrl(alu_ctrl_b), .trap(trap_b), .instret(instret_b), .state(state_b)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                               input logic z, input logic iack, input logic dack,
                               input logic [2:0] st, input logic [9:0] outs,
                               input logic [2:0] alu, input int ret);
      vec_t v;
      v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.iack = iack; v.dack = dack;
      v.st = st; v.outs = outs; v.alu = alu; v.ret = ret;
      return v;
   endfunction

   // Fetch cycle with an immediate ack, and the decode cycle that follows it.
   function automatic vec_t fr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input int ret);
      return mk(op, f3, f7, 1'b0, 1'b1, 1'b0, 3'd0, IREQ | IRW | PCW, ADD, ret);
   endfunction

   function automatic vec_t dr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input int ret);
      return mk(op, f3, f7, 1'b0, 1'b0, 1'b0, 3'd1, 10'h000, ADD, ret);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      @(negedge clk);
      #1;
      opcode = v.op;
      funct3 = v.f3;
      funct7_b5 = v.f7;
      alu_zero = v.z;
      bus32.imem_ack = v.iack;
      bus4.imem_ack = v.iack;
      bus32.dmem_ack = v.dack;
      bus4.dmem_ack = v.dack;
      sb.push_back(v);
   endtask

   task automatic drain();
      repeat (2) @(negedge clk);
      #3;
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic set_acks(input logic v);
      bus32.imem_ack = v;
      bus4.imem_ack = v;
      bus32.dmem_ack = v;
      bus4.dmem_ack = v;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_state"}, 32'(state_a), 32'd0);
      chk({tag, "_strobes"}, 32'(outs_a), 32'd0);
      chk({tag, "_alu"}, 32'(alu_ctrl_a), 32'(ADD));
      chk({tag, "_instret32"}, instret_a, 32'd0);
      chk({tag, "_instret4"}, 32'(instret_b), 32'd0);
      chk({tag, "_state4"}, 32'(state_b), 32'd0);
   endtask

   task automatic do_reset(input string tag);
      set_acks(1'b0);
      alu_zero = 1'b0;
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_vals(tag);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_first_fetch_req"}, 32'(bus32.imem_req), 32'd1);
      chk({tag, "_first_fetch_state"}, 32'(state_a), 32'd0);
   endtask

   // Scoreboard: compare every queued expectation after the cycle's inputs have settled.
   always @(negedge clk) begin
      #2;
      while (sb.size() > 0) begin
         cur = sb.pop_front();
         chk($sformatf("row%0d_state", row_no), 32'(state_a), 32'(cur.st));
         chk($sformatf("row%0d_strobes", row_no), 32'(outs_a), 32'(cur.outs));
         chk($sformatf("row%0d_alu", row_no), 32'(alu_ctrl_a), 32'(cur.alu));
         chk($sformatf("row%0d_instret32", row_no), instret_a, 32'(cur.ret));
         chk($sformatf("row%0d_state4", row_no), 32'(state_b), 32'(cur.st));
         chk($sformatf("row%0d_instret4", row_no), 32'(instret_b), 32'(cur.ret) & 32'hF);
         row_no++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      // Main table: legal instruction mix with waits, spurious acks and both branch outcomes.
      tbl.push_back(fr(ARITH, 3'b000, 1'b0, 0));
      tbl.push_back(dr(ARITH, 3'b000, 1'b0, 0));
      tbl.push_back(mk(ARITH, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 10'h000, ADD, 0));
      tbl.push_back(mk(ARITH, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, RW, ADD, 0));
      tbl.push_back(fr(ARITH, 3'b000, 1'b1, 1));
      tbl.push_back(dr(ARITH, 3'b000, 1'b1, 1));
      tbl.push_back(mk(ARITH, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 10'h000, SUB, 1));
      tbl.push_back(mk(ARITH, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, RW, SUB, 1));
      tbl.push_back(fr(ARITH, 3'b111, 1'b0, 2));
      tbl.push_back(dr(ARITH, 3'b111, 1'b0, 2));
      tbl.push_back(mk(ARITH, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 10'h000, AND, 2));
      tbl.push_back(mk(ARITH, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, RW, AND, 2));
      tbl.push_back(mk(LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, IREQ, ADD, 3));
      tbl.push_back(fr(LOAD, 3'b010, 1'b0, 3));
      tbl.push_back(dr(LOAD, 3'b010, 1'b0, 3));
      tbl.push_back(mk(LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, ASRC, ADD, 3));
      tbl.push_back(mk(LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, DREQ, ADD, 3));
      tbl.push_back(mk(LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, DREQ, ADD, 3));
      tbl.push_back(mk(LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, DREQ, ADD, 3));
      tbl.push_back(mk(LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, DREQ, ADD, 3));
      tbl.push_back(mk(LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, RW | M2R, ADD, 3));
      tbl.push_back(fr(STORE, 3'b010, 1'b0, 4));
      tbl.push_back(dr(STORE, 3'b010, 1'b0, 4));
      tbl.push_back(mk(STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, ASRC, ADD, 4));
      tbl.push_back(mk(STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, DREQ | DWE, ADD, 4));
      tbl.push_back(mk(STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, IREQ, ADD, 5));
      tbl.push_back(mk(STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, IREQ, ADD, 5));
      tbl.push_back(fr(BRANCH, 3'b000, 1'b0, 5));
      tbl.push_back(dr(BRANCH, 3'b000, 1'b0, 5));
      tbl.push_back(mk(BRANCH, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, PCW | PCS, SUB, 5));
      tbl.push_back(fr(BRANCH, 3'b000, 1'b0, 6));
      tbl.push_back(dr(BRANCH, 3'b000, 1'b0, 6));
      tbl.push_back(mk(BRANCH, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 10'h000, SUB, 6));
      tbl.push_back(fr(ARITH, 3'b110, 1'b0, 7));
      tbl.push_back(dr(ARITH, 3'b110, 1'b0, 7));
      tbl.push_back(mk(ARITH, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 10'h000, OR, 7));
      tbl.push_back(mk(ARITH, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, RW, OR, 7));
      tbl.push_back(mk(ARITH, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, IREQ, ADD, 8));

      do_reset("rst0");
      for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);
      drain();

      // Reset asserted while a STORE is waiting in MEM.
      drive(fr(STORE, 3'b010, 1'b0, 8));
      drive(dr(STORE, 3'b010, 1'b0, 8));
      drive(mk(STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, ASRC, ADD, 8));
      drive(mk(STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, DREQ | DWE, ADD, 8));
      #2;
      chk("mid_store_dreq_before", 32'(bus32.dmem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_store_dreq_dropped", 32'(bus32.dmem_req), 32'd0);
      check_reset_vals("mid_store");
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      drain();

      // Illegal opcode: sticky trap, acks ignored, counter frozen, reset exits.
      drive(fr(ARITH, 3'b000, 1'b0, 0));
      drive(dr(ARITH, 3'b000, 1'b0, 0));
      drive(mk(ARITH, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 10'h000, ADD, 0));
      drive(mk(ARITH, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, RW, ADD, 0));
      drive(fr(OP_BAD, 3'b000, 1'b0, 1));
      drive(dr(OP_BAD, 3'b000, 1'b0, 1));
      for (int i = 0; i < 3; i++)
         drive(mk(OP_BAD, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, TRP, ADD, 1));
      drain();
      do_reset("trap_exit");
      chk("trap_cleared", 32'(trap_a), 32'd0);

      // Legal ARITH opcode with an unsupported funct3 traps from EXEC.
      drive(fr(ARITH, 3'b001, 1'b0, 0));
      drive(dr(ARITH, 3'b001, 1'b0, 0));
      drive(mk(ARITH, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 10'h000, ADD, 0));
      drive(mk(ARITH, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, TRP, ADD, 0));
      drain();
      do_reset("funct_trap_exit");

      // Sixteen ARITH retirements wrap the 4-bit counter back to zero.
      for (int i = 0; i < 16; i++) begin
         drive(fr(ARITH, 3'b000, 1'b0, i));
         drive(dr(ARITH, 3'b000, 1'b0, i));
         drive(mk(ARITH, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 10'h000, ADD, i));
         drive(mk(ARITH, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, RW, ADD, i));
      end
      drive(mk(ARITH, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, IREQ, ADD, 16));
      drain();
      chk("wrap_instret4", 32'(instret_b), 32'd0);
      chk("wrap_instret32", instret_a, 32'd16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
